// File: rtl/us_burst_driver.sv
// Ultrasonic burst driver: N complementary square-wave periods aligned to a 40 kHz tick plus phase offset.
// All outputs registered (visible the cycle after the state change); start is ignored while busy.
module us_burst_driver #(
  parameter int PERIOD      = 1250,
  parameter int CNT_W       = 11,
  parameter int DEAD        = 2,
  parameter int HOLDOFF_CYC = 100,
  parameter int LEN_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tick,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [CNT_W-1:0] phase,
  output logic             drv_p,
  output logic             drv_n,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF      = CNT_W'(PERIOD / 2);
  localparam logic [CNT_W-1:0] P_ON      = CNT_W'(DEAD);
  localparam logic [CNT_W-1:0] N_ON      = CNT_W'(PERIOD / 2 + DEAD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    DELAY   = 3'd2,
    BURST   = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ph_q, ph_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] per_q, per_d;
  logic             drv_p_d, drv_n_d, busy_d, done_d;

  // cnt is shared: phase countdown in DELAY, in-period position in BURST, quiet time in HOLDOFF
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    len_d   = len_q;
    per_d   = per_q;
    done_d  = 1'b0;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      per_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort && burst_len != '0) begin
            len_d   = burst_len;
            ph_d    = (phase > LAST) ? LAST : phase;
            state_d = ARM;
          end
        end
        ARM: begin
          if (tick) begin
            cnt_d = '0;
            per_d = '0;
            if (ph_q == '0) begin
              state_d = BURST;
            end else begin
              state_d = DELAY;
              cnt_d   = ph_q - ONE;
            end
          end
        end
        DELAY: begin
          if (cnt_q == '0) begin
            state_d = BURST;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        BURST: begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (per_q == len_q - LEN_ONE) begin
              state_d = HOLDOFF;
              per_d   = '0;
            end else begin
              per_d = per_q + LEN_ONE;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        HOLDOFF: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          per_d   = '0;
        end
      endcase
    end
    // drive levels follow the next-cycle position so the pins line up with cnt
    drv_p_d = (state_d == BURST) && (cnt_d >= P_ON) && (cnt_d < HALF);
    drv_n_d = (state_d == BURST) && (cnt_d >= N_ON);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      len_q   <= '0;
      per_q   <= '0;
      drv_p   <= 1'b0;
      drv_n   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      len_q   <= len_d;
      per_q   <= per_d;
      drv_p   <= drv_p_d;
      drv_n   <= drv_n_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_us_burst_driver.sv
// Bench for us_burst_driver: random and directed bursts checked cycle by cycle against a closed-form
// timeline of each accepted burst (start, tick alignment, period windows, hold-off, abort cut).
module tb_us_burst_driver;

  localparam int PERIOD = 1250;
  localparam int DEAD   = 2;
  localparam int HOLD   = 100;
  localparam int NEVER  = 32'h7fffffff;

  logic        CLK, RST, tick, start, abort;
  logic [7:0]  burst_len;
  logic [10:0] phase;
  logic        drv_p, drv_n, busy, done;

  us_burst_driver dut (
    .CLK(CLK), .RST(RST), .tick(tick), .start(start), .abort(abort),
    .burst_len(burst_len), .phase(phase),
    .drv_p(drv_p), .drv_n(drv_n), .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  typedef struct {
    bit valid;
    int s;
    int b;
    int e;
    int len;
    int cut;
  } job_t;

  job_t cur, prev;
  int   cyc, toff, n_vec, n_bad, overlap;
  bit   scen_bad;
  int   first_p_rise, last_p_fall, first_n_rise, last_n_fall;
  int   p_rises, n_rises, p_hi, busy_hi, done_cnt, done_cyc;
  logic pp, pn;

  always @(negedge CLK) if (drv_p && drv_n) overlap++;

  task automatic check(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic bit tick_sched(input int c);
    return ((c + toff) % PERIOD) == 0;
  endfunction

  function automatic int next_tick_after(input int c);
    for (int k = c + 1; k <= c + PERIOD; k++)
      if (tick_sched(k)) return k;
    return c + PERIOD;
  endfunction

  // {drv_p, drv_n, busy, done} expected from one burst's timeline
  function automatic logic [3:0] job_out(input job_t j, input int c);
    logic p, n, bz, dn;
    int   k;
    p = 0; n = 0; bz = 0; dn = 0;
    if (j.valid && c < j.cut) begin
      bz = (c >= j.s + 1) && (c < j.e);
      dn = (c == j.e);
      if (c >= j.b && c < j.b + j.len * PERIOD) begin
        k = (c - j.b) % PERIOD;
        p = (k >= DEAD) && (k < PERIOD / 2);
        n = (k >= PERIOD / 2 + DEAD);
      end
    end
    return {p, n, bz, dn};
  endfunction

  function automatic logic [3:0] exp_vec(input int c);
    return job_out(prev, c) | job_out(cur, c);
  endfunction

  function automatic bit exp_bit(input int c, input int idx);
    logic [3:0] v;
    v = exp_vec(c);
    return v[idx];
  endfunction

  task automatic reset_stats();
    first_p_rise = -1; last_p_fall = -1; first_n_rise = -1; last_n_fall = -1;
    p_rises = 0; n_rises = 0; p_hi = 0; busy_hi = 0; done_cnt = 0; done_cyc = -1;
    scen_bad = 0;
  endtask

  task automatic track(input logic [3:0] got);
    if (got[3] && !pp) begin p_rises++; if (first_p_rise < 0) first_p_rise = cyc; end
    if (!got[3] && pp) last_p_fall = cyc;
    if (got[2] && !pn) begin n_rises++; if (first_n_rise < 0) first_n_rise = cyc; end
    if (!got[2] && pn) last_n_fall = cyc;
    if (got[3]) p_hi++;
    if (got[1]) busy_hi++;
    if (got[0]) begin done_cnt++; done_cyc = cyc; end
    pp = got[3];
    pn = got[2];
  endtask

  // one clock cycle: compare this cycle's outputs, then drive the inputs seen at the next edge
  task automatic step(input logic st, input logic ab, input logic [7:0] bl, input logic [10:0] ph);
    logic [3:0] got, want;
    int         t, phc;
    got  = {drv_p, drv_n, busy, done};
    want = exp_vec(cyc);
    if (!scen_bad) begin
      check($sformatf("out@%0d", cyc), int'(got), int'(want));
      if (got != want) scen_bad = 1;
    end
    track(got);
    tick = tick_sched(cyc); start = st; abort = ab; burst_len = bl; phase = ph;
    if (ab && want[1]) begin
      cur.cut = cyc + 1;
    end else if (st && !ab && bl != 0 && !want[1]) begin
      prev = cur;
      t    = next_tick_after(cyc);
      phc  = (int'(ph) > PERIOD - 1) ? PERIOD - 1 : int'(ph);
      cur.valid = 1; cur.s = cyc; cur.len = int'(bl);
      cur.b = t + 1 + phc;
      cur.e = cur.b + cur.len * PERIOD + HOLD;
      cur.cut = NEVER;
    end
    @(posedge CLK); cyc++;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 8'd0, 11'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_vec(cyc) != 4'd0 && n < 20000) begin idle(1); n++; end
  endtask

  task automatic wait_until(input int c);
    int n;
    n = 0;
    while (cyc < c && n < 6000) begin idle(1); n++; end
  endtask

  int s, t, n, abort_at, bl_r;

  initial begin
    RST = 1'b1; tick = 0; start = 0; abort = 0; burst_len = 0; phase = 0;
    n_vec = 0; n_bad = 0; overlap = 0; pp = 0; pn = 0;
    cur = '{0, 0, 0, 0, 0, 0}; prev = '{0, 0, 0, 0, 0, 0};
    toff = $urandom_range(0, PERIOD - 1);
    reset_stats();
    repeat (2) @(negedge CLK);
    check("reset_state", int'({drv_p, drv_n, busy, done}), 0);
    RST = 1'b0; cyc = 0;
    idle(5);

    // basic 3-period burst
    reset_stats(); s = cyc; t = next_tick_after(s);
    step(1, 0, 8'd3, 11'd0); drain();
    check("basic_p_rise", first_p_rise - t, 3);
    check("basic_p_count", p_rises, 3);
    check("basic_p_width", p_hi, 3 * 623);
    check("basic_n_rise", first_n_rise - t, 628);
    check("basic_n_count", n_rises, 3);
    check("basic_n_fall", last_n_fall - t, 3751);
    check("basic_done_at", done_cyc - t, 3851);
    check("basic_done_cnt", done_cnt, 1);

    // phase offset 400, then clamp of 2000
    idle(7); reset_stats(); s = cyc; t = next_tick_after(s);
    step(1, 0, 8'd1, 11'd400); drain();
    check("ph400_p_rise", first_p_rise - t, 403);
    check("ph400_p_fall", last_p_fall - t, 1026);
    check("ph400_n_rise", first_n_rise - t, 1028);
    check("ph400_n_fall", last_n_fall - t, 1651);
    idle(3); reset_stats(); s = cyc; t = next_tick_after(s);
    step(1, 0, 8'd1, 11'd2000); drain();
    check("clamp_p_rise", first_p_rise - t, 1252);

    // zero-length start is ignored
    reset_stats(); step(1, 0, 8'd0, 11'd5); idle(20);
    check("len0_busy", busy_hi, 0);
    check("len0_done", done_cnt, 0);

    // start while bursting does not change the latched burst
    reset_stats(); s = cyc; t = next_tick_after(s);
    step(1, 0, 8'd2, 11'd0);
    wait_until(cur.b + 100);
    step(1, 0, 8'd7, 11'd300); drain();
    check("midstart_p_count", p_rises, 2);
    check("midstart_done_at", done_cyc - t, 2601);

    // start coincident with a tick waits for the following tick
    n = 0;
    while (!tick_sched(cyc) && n < PERIOD + 1) begin idle(1); n++; end
    reset_stats(); s = cyc;
    step(1, 0, 8'd1, 11'd0); drain();
    check("coinc_p_rise", first_p_rise - s, PERIOD + 3);

    // abort in the 2nd period of a 5-period burst
    reset_stats();
    step(1, 0, 8'd5, 11'd0);
    wait_until(cur.b + PERIOD + 200);
    step(0, 1, 8'd0, 11'd0);
    check("abort_outputs", int'({drv_p, drv_n, busy, done}), 0);
    idle(5000);
    check("abort_no_done", done_cnt, 0);
    reset_stats(); step(1, 0, 8'd2, 11'd17); drain();
    check("post_abort_done", done_cnt, 1);
    check("post_abort_p_count", p_rises, 2);

    // asynchronous reset while drv_p is high
    reset_stats(); step(1, 0, 8'd2, 11'd0);
    n = 0;
    while (!exp_bit(cyc, 3) && n < 4000) begin idle(1); n++; end
    check("pre_rst_drv_p", int'(drv_p), 1);
    #3 RST = 1'b1;
    #1 check("rst_async_drop", int'({drv_p, drv_n, busy, done}), 0);
    cur.valid = 0; prev.valid = 0; tick = 0; start = 0;
    @(posedge CLK); cyc++;
    @(negedge CLK);
    check("rst_hold", int'({drv_p, drv_n, busy, done}), 0);
    RST = 1'b0;
    idle(1300);
    check("rst_no_done", done_cnt, 0);
    reset_stats(); step(1, 0, 8'd1, 11'd0); drain();
    check("post_rst_done", done_cnt, 1);

    // back-to-back: start on the done cycle
    reset_stats(); step(1, 0, 8'd1, 11'd0);
    n = 0;
    while (!exp_bit(cyc, 0) && n < 4000) begin idle(1); n++; end
    step(1, 0, 8'd1, 11'd0);
    check("b2b_busy", int'(busy), 1);
    drain();
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_p_count", p_rises, 2);

    // randomized bursts with stray starts and occasional aborts
    for (int r = 0; r < 6; r++) begin
      reset_stats();
      idle($urandom_range(0, 40));
      step(1, 0, 8'($urandom_range(1, 2)), 11'($urandom_range(0, 2047)));
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3000)) : -1;
      n = 0;
      while (exp_vec(cyc) != 4'd0 && n < 12000) begin
        bl_r = $urandom_range(0, 3);
        if (n == abort_at) step(0, 1, 8'd0, 11'd0);
        else if (n % 500 == 250) step(1, 0, 8'(bl_r), 11'($urandom_range(0, 2047)));
        else idle(1);
        n++;
      end
      idle(3);
    end

    check("no_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
